// File: rtl/system_top_dual_pico.sv
// Dual-controller XTEA demo. pico1 streams a ROM job into a byte FIFO.
// pico2 drains it, decrypts it and stores the plaintext in mem3.
//
// Ports:
//   clk             - system clock, rising edge
//   rst             - asynchronous active-low reset
//   xtea_ready      - result valid, sticky until reset
//   xtea_result_out - plaintext {v0,v1}

// Byte FIFO, first-word-fall-through.
// Ports: wr_en/din/full write side, rd_en/dout/empty read side.
module byte_fifo #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       full,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_acc, rd_acc;

    assign full   = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign dout   = mem_q[rd_ptr_q];
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
        if (wr_acc && !rd_acc) count_d = count_q + 1'b1;
        if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= din;
    end
endmodule

// 8x8 result RAM, cleared by reset.
// Ports: we/addr/wdata write port.
module result_ram (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] wdata
);
    logic [7:0] ram [0:7];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) ram[i] <= 8'h00;
        end else if (we) begin
            ram[addr] <= wdata;
        end
    end
endmodule

// Iterative XTEA decryption core, one full cycle per clock.
// Ports: start/v_in/k_in request, ready/result sticky response.
module xtea_dec_core #(
    parameter int unsigned ROUNDS = 32,
    parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  v_in,
    input  logic [127:0] k_in,
    output logic         ready,
    output logic [63:0]  result
);
    localparam int RW = $clog2(ROUNDS + 1);
    localparam logic [RW-1:0] LAST = RW'(ROUNDS - 1);
    localparam logic [31:0] SUM_INIT = DELTA * ROUNDS;

    logic          busy_q, busy_d;
    logic [RW-1:0] round_q, round_d;
    logic [31:0]   v0_q, v0_d, v1_q, v1_d;
    logic [31:0]   sum_q, sum_d;
    logic [127:0]  k_q, k_d;
    logic          ready_q, ready_d;
    logic [63:0]   result_q, result_d;
    logic [31:0]   ka, kb, t1, t2, v0_n, v1_n, sum_n;

    function automatic logic [31:0] key_word(
        input logic [127:0] k, input logic [1:0] i);
        case (i)
            2'd0:    return k[127:96];
            2'd1:    return k[95:64];
            2'd2:    return k[63:32];
            default: return k[31:0];
        endcase
    endfunction

    always_comb begin
        busy_d   = busy_q;
        round_d  = round_q;
        v0_d     = v0_q;
        v1_d     = v1_q;
        sum_d    = sum_q;
        k_d      = k_q;
        ready_d  = ready_q;
        result_d = result_q;
        // v1 update uses the old sum, v0 update the decremented one.
        ka    = key_word(k_q, sum_q[12:11]);
        t1    = (((v0_q << 4) ^ (v0_q >> 5)) + v0_q) ^ (sum_q + ka);
        v1_n  = v1_q - t1;
        sum_n = sum_q - DELTA;
        kb    = key_word(k_q, sum_n[1:0]);
        t2    = (((v1_n << 4) ^ (v1_n >> 5)) + v1_n) ^ (sum_n + kb);
        v0_n  = v0_q - t2;
        if (busy_q) begin
            v0_d    = v0_n;
            v1_d    = v1_n;
            sum_d   = sum_n;
            round_d = round_q + 1'b1;
            if (round_q == LAST) begin
                busy_d   = 1'b0;
                ready_d  = 1'b1;
                result_d = {v0_n, v1_n};
            end
        end else if (start && !ready_q) begin
            busy_d  = 1'b1;
            round_d = '0;
            v0_d    = v_in[63:32];
            v1_d    = v_in[31:0];
            k_d     = k_in;
            sum_d   = SUM_INIT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= 1'b0;
            round_q  <= '0;
            v0_q     <= '0;
            v1_q     <= '0;
            sum_q    <= '0;
            k_q      <= '0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            busy_q   <= busy_d;
            round_q  <= round_d;
            v0_q     <= v0_d;
            v1_q     <= v1_d;
            sum_q    <= sum_d;
            k_q      <= k_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign ready  = ready_q;
    assign result = result_q;
endmodule

module system_top_dual_pico #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ROUNDS     = 32,
    parameter logic [31:0] DELTA      = 32'h9E3779B9
) (
    input  logic        clk,
    input  logic        rst,
    output logic        xtea_ready,
    output logic [63:0] xtea_result_out
);
    typedef enum logic [2:0] {
        LOAD, START, WAIT, STORE, HALT
    } state_t;

    logic         wr_en, full, rd_en, empty;
    logic [7:0]   din, dout;
    logic [4:0]   idx_q, idx_d;
    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [191:0] job_q, job_d;
    logic [2:0]   addr_q, addr_d;
    logic         start, ram_we;
    logic [7:0]   ram_wdata;

    // pico1: mem1 ROM feeding the FIFO.
    always_comb begin
        din = 8'h00;
        case (idx_q)
            5'd0: din = 8'hC3;
            5'd1: din = 8'hB9;
            5'd2: din = 8'h0E;
            5'd3: din = 8'hB5;
            5'd4: din = 8'h22;
            5'd5: din = 8'h56;
            5'd6: din = 8'hFE;
            5'd7: din = 8'h61;
            default: if (idx_q < 5'd24) din = {3'b000, idx_q - 5'd8};
        endcase
    end

    assign wr_en = (idx_q < 5'd24) && !full;
    assign idx_d = wr_en ? idx_q + 5'd1 : idx_q;

    byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) fifo_inst (
        .clk  (clk),
        .rst  (rst),
        .wr_en(wr_en),
        .din  (din),
        .full (full),
        .rd_en(rd_en),
        .dout (dout),
        .empty(empty)
    );

    // pico2: drain, decrypt, store.
    assign rd_en = (state_q == LOAD) && !empty;
    assign start = (state_q == START);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        job_d   = job_q;
        addr_d  = addr_q;
        ram_we  = 1'b0;
        case (state_q)
            LOAD: if (rd_en) begin
                job_d = {job_q[183:0], dout};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd23) state_d = START;
            end
            START: state_d = WAIT;
            WAIT:  if (xtea_ready) state_d = STORE;
            STORE: begin
                ram_we = 1'b1;
                if (addr_q == 3'd7) state_d = HALT;
                else addr_d = addr_q + 3'd1;
            end
            default: state_d = HALT;
        endcase
    end

    always_comb begin
        ram_wdata = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (addr_q == 3'(i)) ram_wdata = xtea_result_out[63-8*i -: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            state_q <= LOAD;
            cnt_q   <= '0;
            job_q   <= '0;
            addr_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            job_q   <= job_d;
            addr_q  <= addr_d;
        end
    end

    xtea_dec_core #(.ROUNDS(ROUNDS), .DELTA(DELTA)) core_inst (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .v_in  (job_q[191:128]),
        .k_in  (job_q[127:0]),
        .ready (xtea_ready),
        .result(xtea_result_out)
    );

    result_ram ram_mem3 (
        .clk  (clk),
        .rst  (rst),
        .we   (ram_we),
        .addr (addr_q),
        .wdata(ram_wdata)
    );
endmodule

// File: tb/tb_system_top_dual_pico.sv
// Bench for system_top_dual_pico: reset state, full job, mem3,
// FIFO ordering, mid-run reset and sticky result.
module tb_system_top_dual_pico;
    logic        clk;
    logic        rst;
    logic        xtea_ready;
    logic [63:0] xtea_result_out;

    system_top_dual_pico dut (
        .clk            (clk),
        .rst            (rst),
        .xtea_ready     (xtea_ready),
        .xtea_result_out(xtea_result_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [63:0] exp;
    } vec_t;

    vec_t        tbl[$];
    int          n_err = 0;
    int          n_chk = 0;
    logic [7:0]  wr_log[$];
    logic [7:0]  rd_log[$];
    int          wr_bad = 0;
    int          rd_bad = 0;
    logic [7:0]  job_exp[24];
    logic [63:0] plain;
    logic [7:0]  ram_exp[8];

    function automatic logic [63:0] xtea_model(
        input logic [63:0] c, input logic [127:0] key);
        logic [31:0] v0, v1, sum;
        logic [31:0] k[4];
        k[0] = key[127:96];
        k[1] = key[95:64];
        k[2] = key[63:32];
        k[3] = key[31:0];
        v0 = c[63:32];
        v1 = c[31:0];
        sum = 32'hC6EF3720;
        for (int r = 0; r < 32; r++) begin
            v1 = v1 - ((((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + k[sum[12:11]]));
            sum = sum - 32'h9E3779B9;
            v0 = v0 - ((((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + k[sum[1:0]]));
        end
        return {v0, v1};
    endfunction

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:       return {63'd0, xtea_ready};
            1:       return xtea_result_out;
            2:       return {63'd0, dut.fifo_inst.empty};
            default: return {56'd0, dut.ram_mem3.ram[sel-3]};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) check(tbl[i].name, observe(tbl[i].sel), tbl[i].exp);
    endtask

    task automatic fill_reset_table();
        tbl.delete();
        tbl.push_back('{"rst_ready", 0, 64'd0});
        tbl.push_back('{"rst_result", 1, 64'd0});
        tbl.push_back('{"rst_empty", 2, 64'd1});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{$sformatf("rst_ram%0d", i), 3 + i, 64'd0});
    endtask

    task automatic fill_done_table(input string tag);
        tbl.delete();
        tbl.push_back('{{tag, "_ready"}, 0, 64'd1});
        tbl.push_back('{{tag, "_result"}, 1, plain});
        for (int i = 0; i < 8; i++)
            tbl.push_back('{$sformatf("%s_ram%0d", tag, i), 3 + i,
                            {56'd0, ram_exp[i]}});
    endtask

    task automatic wait_ready(input string tag);
        int cyc = 0;
        while (!xtea_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_in_time"}, {63'd0, cyc <= 64}, 64'd1);
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_wr_count"}, 64'(wr_log.size()), 64'd24);
        check({tag, "_rd_count"}, 64'(rd_log.size()), 64'd24);
        check({tag, "_wr_full"}, 64'(wr_bad), 64'd0);
        check({tag, "_rd_empty"}, 64'(rd_bad), 64'd0);
        for (int i = 0; i < 24; i++) begin
            if (i < wr_log.size())
                check($sformatf("%s_wr%0d", tag, i), {56'd0, wr_log[i]},
                      {56'd0, job_exp[i]});
            if (i < rd_log.size())
                check($sformatf("%s_rd%0d", tag, i), {56'd0, rd_log[i]},
                      {56'd0, job_exp[i]});
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        wr_bad = 0;
        rd_bad = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            if (dut.fifo_inst.wr_en && dut.fifo_inst.full) wr_bad++;
            if (dut.fifo_inst.wr_en && !dut.fifo_inst.full)
                wr_log.push_back(dut.fifo_inst.din);
            if (dut.fifo_inst.rd_en && dut.fifo_inst.empty) rd_bad++;
            if (dut.fifo_inst.rd_en && !dut.fifo_inst.empty)
                rd_log.push_back(dut.fifo_inst.dout);
        end
    end

    initial begin
        logic [63:0]  ct;
        logic [127:0] key;
        ct  = 64'hC3B90EB52256FE61;
        key = 128'h000102030405060708090A0B0C0D0E0F;
        for (int i = 0; i < 8; i++) job_exp[i] = ct[63-8*i -: 8];
        for (int i = 0; i < 16; i++) job_exp[8+i] = key[127-8*i -: 8];
        plain = xtea_model(ct, key);
        for (int i = 0; i < 8; i++) ram_exp[i] = plain[63-8*i -: 8];
        $display("model plaintext %h", plain);

        // Reset state.
        rst = 1'b0;
        repeat (10) @(negedge clk);
        fill_reset_table();
        run_table();

        // First full run.
        clear_logs();
        rst = 1'b1;
        wait_ready("run1");
        check("run1_result_now", xtea_result_out, plain);
        repeat (10) @(negedge clk);
        fill_done_table("run1_10cyc");
        run_table();
        repeat (500) @(negedge clk);
        fill_done_table("run1_500cyc");
        run_table();
        check_logs("run1");

        // Sticky for 1000 more cycles.
        repeat (1000) @(negedge clk);
        fill_done_table("sticky");
        run_table();

        // Async reset after completion clears at once.
        rst = 1'b0;
        #1;
        fill_reset_table();
        run_table();
        @(negedge clk);

        // Reset at cycle 30 of a new run.
        clear_logs();
        rst = 1'b1;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        #1;
        fill_reset_table();
        run_table();
        repeat (3) @(negedge clk);

        // Rerun from scratch.
        clear_logs();
        rst = 1'b1;
        wait_ready("run2");
        repeat (10) @(negedge clk);
        fill_done_table("run2");
        run_table();
        check_logs("run2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
